// File: rtl/btn_debounce_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Board timing constants live here so instances never hard-code cycle counts.
package btn_debounce_pkg;

  localparam int CLK_HZ        = 25_000_000;
  localparam int DEBOUNCE_10MS = 250000;
  localparam int LONG_1S       = 25000000;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity fix, two-flop synchroniser, stability-counter
// debounce, press/release strobes and an optional one-shot long-press strobe.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             cand;
  logic [CNT_W-1:0] cnt;

  // The pin is asynchronous; only s2 may be used by downstream logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes s1->s2 a chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in ^ ACTIVE_LOW;
      s2 <= s1;
    end
  end

  // Any disagreement restarts the count; the count saturates at CNT_LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand        <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt < CNT_LAST) begin
        cnt <= cnt + CNT_ONE;
      end else if (cand != btn_level) begin
        btn_level   <= cand;
        btn_press   <= cand;
        btn_release <= ~cand;
      end
    end
  end

  if (LONG_CYCLES > 0) begin : g_long
    localparam int                HOLD_W    = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold;
    logic              fired;

    // fired latches after the strobe so a single press yields one btn_long.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold     <= '0;
        fired    <= 1'b0;
        btn_long <= 1'b0;
      end else begin
        btn_long <= 1'b0;
        if (!btn_level) begin
          hold  <= '0;
          fired <= 1'b0;
        end else if (!fired) begin
          if (hold == HOLD_LAST) begin
            btn_long <= 1'b1;
            fired    <= 1'b1;
          end else begin
            hold <= hold + HOLD_ONE;
          end
        end
      end
    end
  end else begin : g_no_long
    assign btn_long = 1'b0;
  end

endmodule

// File: rtl/btn_debounce_array.sv
// N-channel button conditioner: one btn_debounce_chan per pin plus a
// registered any_press summary for the control FSMs.
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int              N_CH            = 4,
  parameter int              DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int              LONG_CYCLES     = LONG_1S,
  parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic            any_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

  // Registered so consumers see a glitch-free single-cycle wake-up strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |btn_press;
    end
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed bench for btn_debounce_array with short debounce/long-press times.
module tb_btn_debounce_array;

  localparam int N_CH = 2;
  localparam int DEB  = 8;
  localparam int LNG  = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_long;
  logic            any_press;

  btn_debounce_array #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .ACTIVE_LOW_MASK (2'b10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;

  // Pin encodings: ch1 is active-low, so 2'b10 means both released.
  localparam logic [1:0] IDLE    = 2'b10;
  localparam logic [1:0] CH0     = 2'b11;
  localparam logic [1:0] CH1     = 2'b00;
  localparam logic [1:0] BOTH    = 2'b01;

  typedef struct {
    logic [1:0] in;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic       any;
  } vec_t;

  vec_t tbl[14];

  int checks = 0;
  int errors = 0;

  int press_at[2], press_cnt[2], rel_at[2], rel_cnt[2], long_at[2], long_cnt[2];
  int any_at, any_cnt;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, sample at the next fall.
  task automatic tick(input logic [1:0] v);
    btn_in = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold the pins at v for n edges, recording the first edge index and count
  // of every strobe per channel.
  task automatic watch(input logic [1:0] v, input int n);
    for (int c = 0; c < 2; c++) begin
      press_at[c] = -1; press_cnt[c] = 0;
      rel_at[c]   = -1; rel_cnt[c]   = 0;
      long_at[c]  = -1; long_cnt[c]  = 0;
    end
    any_at = -1; any_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick(v);
      for (int c = 0; c < 2; c++) begin
        if (btn_press[c]) begin
          if (press_at[c] < 0) press_at[c] = k;
          press_cnt[c]++;
        end
        if (btn_release[c]) begin
          if (rel_at[c] < 0) rel_at[c] = k;
          rel_cnt[c]++;
        end
        if (btn_long[c]) begin
          if (long_at[c] < 0) long_at[c] = k;
          long_cnt[c]++;
        end
      end
      if (any_press) begin
        if (any_at < 0) any_at = k;
        any_cnt++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum_p, sum_r;

    for (int i = 0; i < 14; i++) begin
      tbl[i].in    = CH0;
      tbl[i].level = (i >= 10) ? 2'b01 : 2'b00;
      tbl[i].press = (i == 10) ? 2'b01 : 2'b00;
      tbl[i].rel   = 2'b00;
      tbl[i].lng   = 2'b00;
      tbl[i].any   = (i == 11);
    end

    reset  = 1'b1;
    btn_in = IDLE;
    repeat (3) @(negedge clk);
    check("reset_level", btn_level, 0);
    check("reset_strobes", {btn_press, btn_release, btn_long, any_press}, 0);
    reset = 1'b0;
    watch(IDLE, 12);
    check("idle_no_press", press_cnt[0] + press_cnt[1], 0);
    check("idle_level", btn_level, 0);

    // Clean press on ch0, edge by edge.
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].in);
      check($sformatf("clean_level[%0d]", i), btn_level, tbl[i].level);
      check($sformatf("clean_press[%0d]", i), btn_press, tbl[i].press);
      check($sformatf("clean_rel[%0d]", i), btn_release, tbl[i].rel);
      check($sformatf("clean_long[%0d]", i), btn_long, tbl[i].lng);
      check($sformatf("clean_any[%0d]", i), any_press, tbl[i].any);
    end
    watch(IDLE, 14);
    check("clean_rel_at", rel_at[0], 10);
    check("clean_rel_cnt", rel_cnt[0], 1);
    check("clean_rel_level", btn_level, 0);

    // Single-cycle glitch must never reach the level.
    watch(CH0, 1);
    sum_p = press_cnt[0];
    watch(IDLE, 14);
    check("glitch_press", sum_p + press_cnt[0], 0);
    check("glitch_level", btn_level[0], 0);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed.
    sum_p = 0; sum_r = 0;
    for (int s = 0; s < 10; s++) begin
      watch((s % 2 == 0) ? CH0 : IDLE, 3);
      sum_p += press_cnt[0];
      sum_r += rel_cnt[0];
    end
    check("bounce_press", sum_p, 0);
    check("bounce_rel", sum_r, 0);
    watch(CH0, 14);
    check("bounce_press_at", press_at[0], 10);
    check("bounce_press_cnt", press_cnt[0], 1);
    watch(IDLE, 14);
    check("bounce_rel_at", rel_at[0], 10);

    // Active-low ch1.
    watch(CH1, 14);
    check("ch1_press_at", press_at[1], 10);
    check("ch1_level", btn_level, 2'b10);
    check("ch1_ch0_quiet", press_cnt[0], 0);
    watch(IDLE, 14);
    check("ch1_rel_at", rel_at[1], 10);
    check("ch1_level_off", btn_level, 0);

    // Long press, twice.
    watch(CH0, 61);
    check("long1_press_at", press_at[0], 10);
    check("long1_at", long_at[0], 10 + LNG);
    check("long1_cnt", long_cnt[0], 1);
    watch(IDLE, 14);
    check("long1_rel_at", rel_at[0], 10);
    check("long1_no_long_rel", long_cnt[0], 0);
    watch(CH0, 40);
    check("long2_at", long_at[0], 10 + LNG);
    check("long2_cnt", long_cnt[0], 1);
    watch(IDLE, 14);

    // Simultaneous press on both channels.
    watch(BOTH, 14);
    check("sim_press0", press_at[0], 10);
    check("sim_press1", press_at[1], 10);
    check("sim_any_at", any_at, 11);
    check("sim_any_cnt", any_cnt, 1);
    watch(IDLE, 14);
    check("sim_rel0", rel_at[0], 10);
    check("sim_rel1", rel_at[1], 10);

    // Reset mid-count with ch1 already pressed and ch0 at cnt = 5.
    watch(CH1, 14);
    check("rst_pre_level", btn_level, 2'b10);
    for (int i = 0; i < 8; i++) tick(BOTH);
    #2 reset = 1'b1;
    #1;
    check("rst_async_level", btn_level, 0);
    check("rst_async_strobes", {btn_press, btn_release, btn_long, any_press}, 0);
    watch(BOTH, 3);
    check("rst_hold_strobes", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);
    reset = 1'b0;
    watch(BOTH, 14);
    check("rst_exit_press0", press_at[0], 10);
    check("rst_exit_press1", press_at[1], 10);
    check("rst_exit_rel", rel_cnt[0] + rel_cnt[1], 0);
    check("rst_exit_level", btn_level, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
